// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder
// Reads a multiplexed active-low seven-segment bus back into BCD slots.
// Each strobed digit must present the same {an,seg} sample for
// STABLE_CYCLES consecutive cycles before its pattern is decoded and stored.
// Optional feature: define SSD_DEC_SYNC_EN to add a second input register
// stage (two-flop synchroniser); every capture/frame latency grows by 1.
//
// Handshake: frame_valid_o is a single-cycle strobe with no ready; it fires
// on the edge where the capture that completes the captured-mask lands, so
// the completing slot's new value and the strobe are visible together.
module ssd_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [6:0]            seg_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  frame_valid_o,
  output logic [1:0]            dbg_state_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);
  localparam logic [DIGITS-1:0] ONE = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   prev_an_q, prev_an_d;
  logic [6:0]          prev_seg_q, prev_seg_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                frame_q, frame_d;

  logic [DIGITS-1:0]   low;
  logic                active;
  logic                same;
  logic [IW-1:0]       idx;
  logic [3:0]          nib;
  logic                bad;
  logic                capture;
  logic [DIGITS-1:0]   mask_set;

`ifdef SSD_DEC_SYNC_EN
  logic [DIGITS-1:0]   an_s_q, an_s_d;
  logic [6:0]          seg_s_q, seg_s_d;

  // First synchroniser stage, then the compare stage.
  always_comb begin
    an_s_d  = an_i;
    seg_s_d = seg_i;
    an_d    = an_s_q;
    seg_d   = seg_s_q;
  end

  // Extra stage resets to the blanked (inactive) bus value.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_s_q  <= '1;
      seg_s_q <= '1;
    end else begin
      an_s_q  <= an_s_d;
      seg_s_q <= seg_s_d;
    end
  end
`else
  // Single input register feeding the compare stage.
  always_comb begin
    an_d  = an_i;
    seg_d = seg_i;
  end
`endif

  // Strobe qualification: exactly one anode low, plus its index.
  always_comb begin
    low    = ~an_q;
    active = (low != '0) && ((low & (low - ONE)) == '0);
    idx    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (low[i]) idx = IW'(i);
    end
    same = (an_q == prev_an_q) && (seg_q == prev_seg_q);
  end

  // Segment pattern back to nibble; unknown patterns flag an error.
  always_comb begin
    nib = 4'hF;
    bad = 1'b0;
    case (seg_q)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0001100: nib = 4'h9;
      7'b1111110: nib = 4'hA;
      7'b1111111: nib = 4'hB;
      default: begin
        nib = 4'hF;
        bad = 1'b1;
      end
    endcase
  end

  // Stability FSM: counts identical active samples, captures once per run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (!same) begin
          cnt_d = 8'd1;
        end else if (cnt_q == STABLE_LAST - 8'd1) begin
          cnt_d   = STABLE_LAST;
          state_d = HELD;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (!same) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Slot write, captured-mask tracking and frame completion.
  always_comb begin
    bcd_d      = bcd_q;
    err_d      = err_q;
    mask_d     = mask_q;
    frame_d    = 1'b0;
    mask_set   = mask_q | (ONE << idx);
    prev_an_d  = an_q;
    prev_seg_d = seg_q;
    if (capture) begin
      bcd_d[4*idx +: 4] = nib;
      err_d[idx]        = bad;
      if (mask_set == '1) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d = mask_set;
      end
    end
  end

  // State registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      an_q       <= '1;
      seg_q      <= '1;
      prev_an_q  <= '1;
      prev_seg_q <= '1;
      bcd_q      <= '1;
      err_q      <= '0;
      mask_q     <= '0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      prev_an_q  <= prev_an_d;
      prev_seg_q <= prev_seg_d;
      bcd_q      <= bcd_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
    end
  end

  assign bcd_o         = bcd_q;
  assign err_o         = err_q;
  assign frame_valid_o = frame_q;
  assign dbg_state_o   = state_q;

endmodule
